// File: rtl/pkt_mem_if.sv
// Packet buffer bus bundle: ingress stream, engine memory port, egress stream.
interface pkt_mem_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned LEN_W  = 12
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_last;
    logic              in_ready;
    logic              mem_ce;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_width;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_err;
    logic              pkt_ready;
    logic [LEN_W-1:0]  pkt_len;
    logic              proc_done;
    logic              out_valid;
    logic [7:0]        out_data;
    logic              out_last;
    logic              out_ready;
    logic              drop;

    modport master (
        output in_valid, in_data, in_last, mem_ce, mem_we, mem_addr, mem_width,
               mem_wdata, proc_done, out_ready,
        input  in_ready, mem_rdata, mem_err, pkt_ready, pkt_len, out_valid,
               out_data, out_last, drop
    );

    modport slave (
        input  in_valid, in_data, in_last, mem_ce, mem_we, mem_addr, mem_width,
               mem_wdata, proc_done, out_ready,
        output in_ready, mem_rdata, mem_err, pkt_ready, pkt_len, out_valid,
               out_data, out_last, drop
    );
endinterface

// File: rtl/pkt_mem.sv
// Byte-addressed packet buffer: captures an ingress packet, serves engine
// random access while held, then streams the edited packet out.
module pkt_mem #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DEPTH  = 2048,
    parameter int unsigned LEN_W  = 12
) (
    input  logic     clk,
    input  logic     rst,
    pkt_mem_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned SUM_W = ADDR_W + 1;

    typedef enum logic [2:0] {IDLE, RX, HOLD, TX, DRAIN} state_t;

    state_t           state;
    logic [LEN_W-1:0] count;
    logic [LEN_W-1:0] rd_ptr;
    logic [LEN_W-1:0] pkt_len;
    logic             pkt_ready;
    logic             out_valid;
    logic             drop;
    logic [7:0]       buf_mem [DEPTH];

    logic [2:0]       nbytes;
    logic             acc_ok;
    logic             mem_err_c;
    logic             mem_wr;
    logic             ing_wr;
    logic [IDX_W-1:0] ing_idx;
    logic [IDX_W-1:0] lane_idx [4];
    logic [31:0]      wdata_top;
    logic [31:0]      rdata_c;
    logic [LEN_W-1:0] last_idx;
    logic             rx_state;

    // Memory-port request decode: legality, lane addresses, big-endian read assembly
    always_comb begin
        nbytes = 3'd0;
        case (bus.mem_width)
            4'd1:    nbytes = 3'd1;
            4'd2:    nbytes = 3'd2;
            4'd4:    nbytes = 3'd4;
            default: nbytes = 3'd0;
        endcase
        acc_ok = (nbytes != 3'd0) && (state == HOLD) &&
                 ((SUM_W'(bus.mem_addr) + SUM_W'(nbytes)) <= SUM_W'(DEPTH));
        mem_err_c = bus.mem_ce && !acc_ok;
        mem_wr    = bus.mem_ce && bus.mem_we && acc_ok;
        for (int k = 0; k < 4; k++) begin
            lane_idx[k] = IDX_W'(bus.mem_addr + ADDR_W'(k));
        end
        // Left-justify write data so lane k always takes byte 3-k
        case (nbytes)
            3'd1:    wdata_top = {bus.mem_wdata[7:0], 24'h0};
            3'd2:    wdata_top = {bus.mem_wdata[15:0], 16'h0};
            default: wdata_top = bus.mem_wdata;
        endcase
        rdata_c = 32'h0;
        if (bus.mem_ce && !bus.mem_we && acc_ok) begin
            for (int k = 0; k < 4; k++) begin
                if (3'(k) < nbytes) begin
                    rdata_c = {rdata_c[23:0], buf_mem[lane_idx[k]]};
                end
            end
        end
    end

    // Ingress write steering: first byte lands at 0, later ones at count unless full
    always_comb begin
        rx_state = (state == IDLE) || (state == RX) || (state == DRAIN);
        ing_wr   = bus.in_valid &&
                   ((state == IDLE) || ((state == RX) && (count != LEN_W'(DEPTH))));
        ing_idx  = (state == IDLE) ? '0 : IDX_W'(count);
        last_idx = pkt_len - LEN_W'(1);
    end

    // Buffer storage; ingress and engine writes are confined to disjoint states
    always_ff @(posedge clk) begin
        if (ing_wr) begin
            buf_mem[ing_idx] <= bus.in_data;
        end else if (mem_wr) begin
            for (int k = 0; k < 4; k++) begin
                if (3'(k) < nbytes) begin
                    buf_mem[lane_idx[k]] <= wdata_top[31-8*k -: 8];
                end
            end
        end
    end

    // Packet lifecycle FSM with registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            rd_ptr    <= '0;
            pkt_len   <= '0;
            pkt_ready <= 1'b0;
            out_valid <= 1'b0;
            drop      <= 1'b0;
        end else begin
            drop <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        count <= LEN_W'(1);
                        if (bus.in_last) begin
                            pkt_len   <= LEN_W'(1);
                            pkt_ready <= 1'b1;
                            state     <= HOLD;
                        end else begin
                            state <= RX;
                        end
                    end
                end
                RX: begin
                    if (bus.in_valid) begin
                        if (count == LEN_W'(DEPTH)) begin
                            drop  <= 1'b1;
                            state <= bus.in_last ? IDLE : DRAIN;
                        end else begin
                            count <= count + LEN_W'(1);
                            if (bus.in_last) begin
                                pkt_len   <= count + LEN_W'(1);
                                pkt_ready <= 1'b1;
                                state     <= HOLD;
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (bus.in_valid && bus.in_last) begin
                        state <= IDLE;
                    end
                end
                HOLD: begin
                    if (bus.proc_done) begin
                        pkt_ready <= 1'b0;
                        out_valid <= 1'b1;
                        rd_ptr    <= '0;
                        state     <= TX;
                    end
                end
                TX: begin
                    if (bus.out_ready) begin
                        if (rd_ptr == last_idx) begin
                            out_valid <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            rd_ptr <= rd_ptr + LEN_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Output drive; egress byte and last flag are decoded from registered pointers
    assign bus.in_ready  = rx_state;
    assign bus.mem_rdata = rdata_c;
    assign bus.mem_err   = mem_err_c;
    assign bus.pkt_ready = pkt_ready;
    assign bus.pkt_len   = pkt_len;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_valid ? buf_mem[IDX_W'(rd_ptr)] : 8'h0;
    assign bus.out_last  = out_valid && (rd_ptr == last_idx);
    assign bus.drop      = drop;
endmodule

// File: tb/tb_pkt_mem.sv
// Directed bench for pkt_mem: capture, engine access, egress, overflow, reset abort.
module tb_pkt_mem;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DEPTH  = 2048;
    localparam int unsigned LEN_W  = 12;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    int   drop_cnt;
    int   drop_at;
    logic rdy_seen;
    logic [7:0] exp_b [20];

    pkt_mem_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

    pkt_mem #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_pkt(input int n, input int base);
        drop_cnt = 0;
        drop_at  = -1;
        rdy_seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(base + i);
            bus.in_last  = (i == n - 1);
            tick();
            if (bus.drop) begin
                drop_cnt++;
                drop_at = i;
            end
            if (bus.pkt_ready && i != n - 1) rdy_seen = 1'b1;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic mem_req(input logic we, input int addr, input int width, input logic [31:0] data);
        bus.mem_ce    = 1'b1;
        bus.mem_we    = we;
        bus.mem_addr  = ADDR_W'(addr);
        bus.mem_width = 4'(width);
        bus.mem_wdata = data;
        #1;
    endtask

    initial begin
        int idx;
        int cyc;
        logic tog;
        logic [7:0] held;
        logic was_stall;

        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < 20; i++) exp_b[i] = 8'(i);
        exp_b[10] = 8'hBE;
        exp_b[11] = 8'hEF;

        rst = 1'b1;
        bus.in_valid = 0; bus.in_data = 0; bus.in_last = 0;
        bus.mem_ce = 0; bus.mem_we = 0; bus.mem_addr = 0; bus.mem_width = 0; bus.mem_wdata = 0;
        bus.proc_done = 0; bus.out_ready = 0;
        tick();
        tick();
        rst = 1'b0;

        // reset state
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_pkt_ready", bus.pkt_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_pkt_len", bus.pkt_len, 0);

        // 1: capture 20 bytes, same-cycle read
        send_pkt(20, 0);
        check("t1_pkt_ready", bus.pkt_ready, 1);
        check("t1_pkt_len", bus.pkt_len, 20);
        check("t1_in_ready", bus.in_ready, 0);
        mem_req(0, 4, 2, 0);
        check("t1_rd_w2", bus.mem_rdata, 32'h0000_0405);
        check("t1_rd_err", bus.mem_err, 0);

        // 2: write then read-after-write
        tick();
        mem_req(1, 10, 2, 32'h0000_BEEF);
        check("t2_wr_err", bus.mem_err, 0);
        tick();
        mem_req(0, 9, 4, 0);
        check("t2_raw", bus.mem_rdata, 32'h09BE_EF0C);
        check("t2_err", bus.mem_err, 0);

        // 3: range / width errors, last-byte write, illegal write ignored
        mem_req(0, DEPTH - 2, 4, 0);
        check("t3_range_err", bus.mem_err, 1);
        check("t3_range_data", bus.mem_rdata, 0);
        mem_req(0, 0, 3, 0);
        check("t3_width_err", bus.mem_err, 1);
        check("t3_width_data", bus.mem_rdata, 0);
        mem_req(0, DEPTH - 4, 4, 0);
        check("t3_edge_ok", bus.mem_err, 0);
        mem_req(1, DEPTH - 1, 1, 32'h0000_00A5);
        check("t3_wr_last_err", bus.mem_err, 0);
        tick();
        mem_req(1, 0, 3, 32'h00FF_FFFF);
        tick();
        mem_req(0, DEPTH - 1, 1, 0);
        check("t3_rd_last", bus.mem_rdata, 32'h0000_00A5);
        bus.mem_ce = 1'b0;
        #1;
        check("t3_idle_data", bus.mem_rdata, 0);
        check("t3_idle_err", bus.mem_err, 0);

        // 4: egress with toggling ready
        bus.proc_done = 1'b1;
        tick();
        bus.proc_done = 1'b0;
        check("t4_pkt_ready_drop", bus.pkt_ready, 0);
        idx = 0;
        cyc = 0;
        tog = 1'b1;
        was_stall = 1'b0;
        held = 8'h0;
        while (idx < 20 && cyc < 200) begin
            bus.out_ready = tog;
            #1;
            check("t4_valid", bus.out_valid, 1);
            check("t4_data", bus.out_data, exp_b[idx]);
            check("t4_last", bus.out_last, (idx == 19));
            if (was_stall) check("t4_stable", bus.out_data, held);
            was_stall = !tog;
            held = bus.out_data;
            if (tog) idx++;
            tog = !tog;
            tick();
            cyc++;
        end
        check("t4_count", idx, 20);
        bus.out_ready = 1'b0;
        check("t4_idle_in_ready", bus.in_ready, 1);
        check("t4_idle_valid", bus.out_valid, 0);

        // 5: overflow packet, then a normal 4-byte packet
        send_pkt(DEPTH + 5, 0);
        check("t5_drop_cnt", drop_cnt, 1);
        check("t5_drop_at", drop_at, DEPTH);
        check("t5_no_ready", rdy_seen, 0);
        check("t5_end_ready", bus.pkt_ready, 0);
        check("t5_in_ready", bus.in_ready, 1);
        send_pkt(4, 8'hA0);
        check("t5_pkt_ready", bus.pkt_ready, 1);
        check("t5_pkt_len", bus.pkt_len, 4);
        mem_req(0, 0, 4, 0);
        check("t5_data", bus.mem_rdata, 32'hA0A1_A2A3);
        bus.mem_ce = 1'b0;

        // single-byte packet after draining the 4-byte one
        bus.proc_done = 1'b1;
        tick();
        bus.proc_done = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        bus.out_ready = 1'b0;
        send_pkt(1, 8'h5A);
        check("t5b_len1", bus.pkt_len, 1);
        bus.proc_done = 1'b1;
        tick();
        bus.proc_done = 1'b0;
        check("t5b_byte", bus.out_data, 8'h5A);
        check("t5b_last", bus.out_last, 1);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("t5b_done", bus.out_valid, 0);

        // 6: reset during egress
        send_pkt(10, 8'h30);
        bus.proc_done = 1'b1;
        tick();
        bus.proc_done = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        check("t6_byte7", bus.out_data, 8'h37);
        rst = 1'b1;
        bus.out_ready = 1'b0;
        tick();
        check("t6_valid", bus.out_valid, 0);
        check("t6_data", bus.out_data, 0);
        check("t6_last", bus.out_last, 0);
        check("t6_pkt_ready", bus.pkt_ready, 0);
        check("t6_pkt_len", bus.pkt_len, 0);
        check("t6_drop", bus.drop, 0);
        check("t6_in_ready", bus.in_ready, 1);
        rst = 1'b0;
        mem_req(0, 0, 1, 0);
        check("t6_mem_err", bus.mem_err, 1);
        check("t6_mem_data", bus.mem_rdata, 0);
        bus.mem_ce = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pkt_mem.md
Name: pkt_mem

Overview:
- Byte-addressed packet buffer. Acts as the memory responder for the processing engines' mem_* initiator port (ce/we/addr/width/data).
- Captures a packet from an ingress byte stream and exposes it to processing engines (checksum, field editors) for random read/write.
- Streams the edited packet out on an egress byte stream.
- Sits between the MAC-side byte streams and the engine mux.

Parameters:
ADDR_W, 16, byte address width of mem port.
DEPTH, 2048, buffer size in bytes; maximum packet length.
LEN_W, 12, width of packet length counter; must satisfy 2^LEN_W > DEPTH.

Ports:
clk  in  1  clock
rst  in  1  reset
in_valid_i  in  1  ingress byte valid
in_data_i  in  8  ingress byte
in_last_i  in  1  last byte of packet
in_ready_o  out  1  buffer accepts ingress byte
mem_ce_i  in  1  mem request enable
mem_we_i  in  1  1 = write, 0 = read
mem_addr_i  in  ADDR_W  byte address
mem_width_i  in  4  access bytes: 1, 2 or 4
mem_data_i  in  32  write data, right-aligned
mem_data_o  out  32  read data, right-aligned, zero-extended
mem_err_o  out  1  current request invalid (range/width/state)
pkt_ready_o  out  1  packet held, mem port live
pkt_len_o  out  LEN_W  captured packet length in bytes
proc_done_i  in  1  engines finished; release packet to egress
out_valid_o  out  1  egress byte valid
out_data_o  out  8  egress byte
out_last_o  out  1  last egress byte
out_ready_i  in  1  egress sink accepts byte
drop_o  out  1  one-cycle pulse: ingress packet overflowed, discarded

Behaviour:
- Reset is rst, synchronous, active-high; clock is clk. All registered outputs are 0 at reset. State is IDLE.
- Reset mid-operation aborts any packet; buffer contents become don't-care.
- FSM states: IDLE, RX, HOLD, TX, DRAIN.
- IDLE: in_ready_o=1.
  - A valid byte is written at address 0, count=1.
  - Go to RX, or to HOLD if in_last_i.
- RX: in_ready_o=1. Each valid byte is written at address count, and count increments.
  - On the in_last_i byte, pkt_len_o is set to the final count and the state goes to HOLD.
  - If a byte arrives with count==DEPTH (buffer full), it is not stored. drop_o pulses and the state goes to DRAIN; if that byte has in_last_i, go straight to IDLE.
- DRAIN: in_ready_o=1. Bytes are discarded until in_last_i, then go to IDLE.
- HOLD: pkt_ready_o=1 and in_ready_o=0. The mem port is live.
  - proc_done_i=1 causes the transition to TX with the read pointer at 0. pkt_ready_o drops the same edge.
- Mem port is combinational read with synchronous write, and is serviced only in HOLD.
  - Read: mem_data_o is valid the same cycle as mem_ce_i/mem_addr_i, with no wait states. Initiators sample it in the cycle they present the address.
  - Byte order is big-endian/network. Width 2 at A gives {buf[A], buf[A+1]} in bits [15:0]. Width 4 gives {buf[A]..buf[A+3]}. Width 1 gives buf[A] in bits [7:0]. Upper bits are 0.
  - Write: the low width bytes of mem_data_i are written big-endian at A..A+width-1 on the clock edge.
  - Read-after-write to the same address in the next cycle returns the new data.
  - An error is raised when A+width > DEPTH, when width is not in {1,2,4}, or when the state is not HOLD. In that case mem_err_o=1 (combinational, qualified by mem_ce_i), reads return 0, and writes are ignored.
  - Access beyond pkt_len_o but within DEPTH is legal.
  - mem_ce_i=0 gives mem_data_o=0 and mem_err_o=0.
- TX: out_data_o=buf[rd_ptr] and out_valid_o=1.
  - On out_valid_o && out_ready_i, rd_ptr increments.
  - out_last_o=1 when rd_ptr==pkt_len_o-1.
  - Once the last byte is accepted, go to IDLE.
  - Outputs are held stable while out_ready_i=0.
- Zero-length packets cannot occur: the first byte always counts, so pkt_len_o >= 1.

Test Plan:
1. Ingress 20 bytes 0x00..0x13 (last on byte 19), then idle -> pkt_ready_o=1, pkt_len_o=20. A width-2 read at addr 4 gives mem_data_o=0x00000405 in the same cycle.
2. In HOLD, write width 2 at addr 10 with data 0xBEEF, then width-4 read at addr 9 the next cycle -> 0x09BEEF0C, mem_err_o=0.
3. In HOLD, read width 4 at addr DEPTH-2 and read width 3 at addr 0 -> mem_err_o=1 and data 0 for both. A width-1 write at DEPTH-1 succeeds.
4. Pulse proc_done_i, with out_ready_i toggling 1,0,1,... -> 20 bytes out in order, reflecting the scenario-2 edits. Data is stable while stalled, out_last_o is set on byte 19, and the state returns to IDLE (in_ready_o=1).
5. Ingress DEPTH+5 bytes -> drop_o pulses once at byte DEPTH+1. pkt_ready_o never rises, and the state returns to IDLE after the last byte. A following 4-byte packet is captured correctly with pkt_len_o=4.
6. Assert rst during TX at byte 7 -> the next cycle has all outputs 0 and in_ready_o=1 (IDLE). mem_err_o=1 for any mem_ce_i request.
